// File: rtl/spi_alu_slave.sv
// spi_alu_slave
//   SPI-style serial ALU slave. The master clocks in a frame of
//   1 start bit, operand A, operand B and a 4-bit opcode, MSB first.
//   The result is latched onto the outputs when the last opcode bit is
//   sampled. The previous result is shifted back out on MISO during the
//   next frame.
//
// Ports
//   clk_arduino  in   serial clock from the master, the only clock
//   reset        in   asynchronous active-high reset
//   CS           in   chip select, active-low
//   MOSI         in   serial data from the master
//   MISO         out  serial readback of the previous result (registered)
//   leds         out  result of the last completed frame
//   carry        out  carry/borrow/overflow flag of the last frame
//   zero         out  leds == 0 after the last frame
//   op_err       out  last frame carried an undefined opcode
//   frame_err    out  sticky: a frame was aborted by CS rising early
//   done         out  one-cycle pulse after a frame completes
module spi_alu_slave #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 4
) (
    input  logic             clk_arduino,
    input  logic             reset,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    output logic [WIDTH-1:0] leds,
    output logic             carry,
    output logic             zero,
    output logic             op_err,
    output logic             frame_err,
    output logic             done
);

    localparam int MAXW  = (WIDTH > OP_W) ? WIDTH : OP_W;
    localparam int CNT_W = $clog2(MAXW);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        RX_OP,
        DONE,
        SKIP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [OP_W-2:0]  op_sh;     // last opcode bit comes straight from MOSI
    logic [WIDTH-1:0] miso_sh;   // readback bits still to be sent, MSB first
    logic [WIDTH+1:0] alu_out;   // {op_err, carry, result}

    // Returns {op_err, carry, result}.
    function automatic logic [WIDTH+1:0] alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [OP_W-1:0]  op);
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   sh;
        logic [WIDTH-1:0]   res;
        logic               c;
        logic               err;
        wide = '0;
        res  = '0;
        c    = 1'b0;
        err  = 1'b0;
        sh   = WIDTH'(32'(b) % WIDTH);
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            4'b0000: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            4'b0001: begin
                // Top bit of the extended difference is the borrow.
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            4'b0010: res = a & b;
            4'b0011: res = a | b;
            4'b0100: res = a ^ b;
            4'b0101: res = a << sh;
            4'b0110: res = a >> sh;
            4'b0111: begin
                res = prod[WIDTH-1:0];
                c   = |prod[2*WIDTH-1:WIDTH];
            end
            default: err = 1'b1;
        endcase
        return {err, c, res};
    endfunction

    assign alu_out = alu(a_sh, b_sh, {op_sh, MOSI});

    always_ff @(posedge clk_arduino or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            op_sh     <= '0;
            miso_sh   <= '0;
            MISO      <= 1'b0;
            leds      <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            op_err    <= 1'b0;
            frame_err <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (CS) begin
                // Deselect mid-reception is an abort; results stay untouched.
                if (state == RX_A || state == RX_B || state == RX_OP)
                    frame_err <= 1'b1;
                state <= IDLE;
                cnt   <= '0;
                MISO  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (MOSI) begin
                            state   <= RX_A;
                            MISO    <= leds[WIDTH-1];
                            miso_sh <= {leds[WIDTH-2:0], 1'b0};
                        end else begin
                            state <= SKIP;
                            MISO  <= 1'b0;
                        end
                    end
                    RX_A: begin
                        a_sh    <= {a_sh[WIDTH-2:0], MOSI};
                        MISO    <= miso_sh[WIDTH-1];
                        miso_sh <= miso_sh << 1;
                        if (cnt == DATA_LAST) begin
                            cnt   <= '0;
                            state <= RX_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_B: begin
                        b_sh    <= {b_sh[WIDTH-2:0], MOSI};
                        MISO    <= miso_sh[WIDTH-1];
                        miso_sh <= miso_sh << 1;
                        if (cnt == DATA_LAST) begin
                            cnt   <= '0;
                            state <= RX_OP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_OP: begin
                        op_sh   <= {op_sh[OP_W-3:0], MOSI};
                        MISO    <= miso_sh[WIDTH-1];
                        miso_sh <= miso_sh << 1;
                        if (cnt == OP_LAST) begin
                            cnt       <= '0;
                            state     <= DONE;
                            leds      <= alu_out[WIDTH-1:0];
                            carry     <= alu_out[WIDTH];
                            op_err    <= alu_out[WIDTH+1];
                            zero      <= (alu_out[WIDTH-1:0] == '0);
                            frame_err <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE, SKIP: MISO <= 1'b0;
                    default: begin
                        state <= IDLE;
                        MISO  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_alu_slave.sv
// tb_spi_alu_slave
//   Directed frames for spi_alu_slave (WIDTH=4). Each full frame pushes its
//   hand-computed expected outputs into a queue; a separate monitor pops and
//   compares whenever done pulses. Aborts, skipped frames, MISO readback and
//   reset are checked directly by the driver.
module tb_spi_alu_slave;

    logic       clk_arduino = 1'b0;
    logic       reset;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic [3:0] leds;
    logic       carry;
    logic       zero;
    logic       op_err;
    logic       frame_err;
    logic       done;

    typedef struct packed {
        logic [3:0] leds;
        logic       carry;
        logic       zero;
        logic       op_err;
        logic       frame_err;
    } res_t;

    res_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [12:0] cap;

    spi_alu_slave #(.WIDTH(4), .OP_W(4)) dut (
        .clk_arduino(clk_arduino),
        .reset      (reset),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .leds       (leds),
        .carry      (carry),
        .zero       (zero),
        .op_err     (op_err),
        .frame_err  (frame_err),
        .done       (done)
    );

    always #5 clk_arduino = ~clk_arduino;

    function automatic res_t mk(input logic [3:0] l, input logic c, input logic z,
                                input logic oe, input logic fe);
        return {l, c, z, oe, fe};
    endfunction

    function automatic res_t now_out();
        return {leds, carry, zero, op_err, frame_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send the first n bits of v (MSB first), capturing MISO after each edge.
    task automatic send_bits(input logic [12:0] v, input int n);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_arduino);
            CS   = 1'b0;
            MOSI = v[12-i];
            @(posedge clk_arduino);
            #1 cap = {cap[11:0], MISO};
        end
    endtask

    task automatic end_frame();
        @(negedge clk_arduino);
        CS   = 1'b1;
        MOSI = 1'b0;
        @(posedge clk_arduino);
        #1;
    endtask

    task automatic frame(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input res_t e);
        exp_q.push_back(e);
        send_bits({1'b1, a, b, op}, 13);
        end_frame();
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk_arduino);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no frame completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_result", 32'(now_out()), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        CS    = 1'b1;
        MOSI  = 1'b0;
        repeat (2) @(negedge clk_arduino);
        chk("reset_state", 32'({now_out(), done, MISO}), 32'd0);
        reset = 1'b0;

        frame(4'b1100, 4'b0110, 4'b0000, mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0)); // ADD 12+6
        frame(4'b1100, 4'b0110, 4'b0001, mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0)); // SUB
        chk("miso_readback_0010", 32'(cap), 32'(13'b0010000000000));
        frame(4'b1100, 4'b0110, 4'b0111, mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0)); // MUL 72
        chk("miso_readback_0110", 32'(cap), 32'(13'b0110000000000));
        frame(4'b1100, 4'b0110, 4'b1100, mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0)); // undefined
        frame(4'b0101, 4'b0011, 4'b0010, mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0)); // AND

        // OR, followed by extra bits in DONE that must be ignored.
        exp_q.push_back(mk(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0));
        send_bits({1'b1, 4'b0101, 4'b0011, 4'b0011}, 13);
        send_bits(13'h1FFF, 5);
        end_frame();
        chk("done_ignores_bits", 32'(now_out()), 32'(mk(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0)));

        frame(4'b0101, 4'b0011, 4'b0100, mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0)); // XOR
        frame(4'b0011, 4'b0110, 4'b0101, mk(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0)); // SLL by 2
        frame(4'b1100, 4'b0101, 4'b0110, mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0)); // SRL by 1
        frame(4'b0011, 4'b0101, 4'b0001, mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0)); // SUB borrow

        // Start bit 0: whole frame skipped, MISO held low.
        send_bits({1'b0, 4'b1111, 4'b1111, 4'b0000}, 13);
        chk("skip_miso_low", 32'(cap), 32'd0);
        end_frame();
        chk("skip_unchanged", 32'(now_out()), 32'(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0)));

        // Abort after 6 data bits.
        send_bits({1'b1, 4'b1010, 4'b0110, 4'b0000}, 7);
        end_frame();
        chk("abort_frame_err", 32'(now_out()), 32'(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b1)));

        frame(4'b1000, 4'b1000, 4'b0000, mk(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0)); // ADD wrap, clears frame_err

        // Abort again, then reset in the middle of RX_B.
        send_bits({1'b1, 4'b1010, 4'b0110, 4'b0000}, 3);
        end_frame();
        chk("abort2_frame_err", 32'(frame_err), 32'd1);
        send_bits({1'b1, 4'b0111, 4'b0110, 4'b0000}, 7);
        #2 reset = 1'b1;
        CS = 1'b1;
        #1 chk("reset_mid_frame", 32'({now_out(), done, MISO}), 32'd0);
        @(negedge clk_arduino);
        reset = 1'b0;
        @(negedge clk_arduino);

        frame(4'b0111, 4'b0001, 4'b0000, mk(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0)); // ADD after reset
        chk("miso_after_reset", 32'(cap), 32'd0);

        repeat (3) @(negedge clk_arduino);
        chk("all_frames_done", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
